regfile_wb: RTL and testbench

- General-purpose register file at the consuming end of the write-back interface: it accepts the WB-stage write (rd enable, address, data) and serves two combinational read ports to the ID stage.
- After reset, an internal sequencer clears all architectural registers one per cycle. Until clearing completes it holds the pipeline through a stall request to the stall controller.
- Same-cycle WB writes are bypassed to the read ports. x0 is hardwired to zero.

---
 rtl/regfile_wb_if.sv | 25 ++
 rtl/regfile_wb.sv | 42 ++++
 tb/tb_regfile_wb.sv | 82 ++++++++
 3 files changed

// File: rtl/regfile_wb_if.sv
// regfile_wb_if: WB write port, two ID read ports and ready/stall status of the register file
interface regfile_wb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              wb_rd_enable;
    logic [ADDR_W-1:0] wb_rd_addr;
    logic [DATA_W-1:0] wb_rd_data;
    logic              rs1_enable;
    logic [ADDR_W-1:0] rs1_addr;
    logic [DATA_W-1:0] rs1_data;
    logic              rs2_enable;
    logic [ADDR_W-1:0] rs2_addr;
    logic [DATA_W-1:0] rs2_data;
    logic              rf_ready;
    logic              rf_stall_req;
    modport master (
        output wb_rd_enable, wb_rd_addr, wb_rd_data, rs1_enable, rs1_addr, rs2_enable, rs2_addr,
        input  rs1_data, rs2_data, rf_ready, rf_stall_req
    );
    modport slave (
        input  wb_rd_enable, wb_rd_addr, wb_rd_data, rs1_enable, rs1_addr, rs2_enable, rs2_addr,
        output rs1_data, rs2_data, rf_ready, rf_stall_req
    );
endinterface

// File: rtl/regfile_wb.sv
// regfile_wb: register file with post-reset clear sequencer, WB bypass and hardwired x0
module regfile_wb #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 5,
    parameter int REG_NUM        = 32,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input logic         clk,
    input logic         rst,
    regfile_wb_if.slave rf
);
    typedef enum logic {CLEAR, RUN} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_idx;
    logic              ready_d;
    logic [DATA_W-1:0] regs [REG_NUM];
    always_ff @(posedge clk) begin
        state_q         <= rst ? (CLEAR_ON_RESET ? CLEAR : RUN) : state_d;
        clr_idx         <= rst ? '0 : (state_q == CLEAR ? clr_idx + 1'b1 : clr_idx);
        rf.rf_ready     <= rst ? !CLEAR_ON_RESET : ready_d;
        rf.rf_stall_req <= rst ? CLEAR_ON_RESET : !ready_d;
    end
    always_comb begin
        state_d = (state_q == CLEAR && clr_idx == ADDR_W'(REG_NUM - 1)) ? RUN : state_q;
    end
    // the clear write owns the array while clearing; WB writes are dropped then
    always_ff @(posedge clk) begin
        if (state_q == CLEAR)
            regs[clr_idx] <= '0;
        else if (rf.wb_rd_enable && rf.wb_rd_addr != '0)
            regs[rf.wb_rd_addr] <= rf.wb_rd_data;
    end
    always_comb begin
        ready_d     = state_d == RUN;
        rf.rs1_data = (state_q == CLEAR || !rf.rs1_enable || rf.rs1_addr == '0) ? '0 :
                      (rf.wb_rd_enable && rf.wb_rd_addr == rf.rs1_addr) ? rf.wb_rd_data :
                      regs[rf.rs1_addr];
        rf.rs2_data = (state_q == CLEAR || !rf.rs2_enable || rf.rs2_addr == '0) ? '0 :
                      (rf.wb_rd_enable && rf.wb_rd_addr == rf.rs2_addr) ? rf.wb_rd_data :
                      regs[rf.rs2_addr];
    end
endmodule

// File: tb/tb_regfile_wb.sv
// tb_regfile_wb: random and directed checks of regfile_wb against a behavioural model
module tb_regfile_wb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    logic [31:0] mdl [32];
    bit m_ready = 1'b0;
    int m_cnt = 0;
    regfile_wb_if #(.DATA_W(32), .ADDR_W(5)) rf();
    regfile_wb dut (.clk(clk), .rst(rst), .rf(rf));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] exp_rd(input logic e, input logic [4:0] a);
        if (!m_ready || !e || a == 5'd0) return 32'd0;
        if (rf.wb_rd_enable && rf.wb_rd_addr == a) return rf.wb_rd_data;
        return mdl[a];
    endfunction
    task automatic cycle(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2);
        @(negedge clk);
        rst = r;
        rf.wb_rd_enable = we; rf.wb_rd_addr = wa; rf.wb_rd_data = wd;
        rf.rs1_enable = e1; rf.rs1_addr = a1; rf.rs2_enable = e2; rf.rs2_addr = a2;
        #1;
        check("rs1", rf.rs1_data, exp_rd(e1, a1));
        check("rs2", rf.rs2_data, exp_rd(e2, a2));
        check("ready", {31'd0, rf.rf_ready}, {31'd0, m_ready});
        check("stall", {31'd0, rf.rf_stall_req}, {31'd0, !m_ready});
        @(posedge clk);
        if (r) begin
            m_ready = 1'b0;
            m_cnt = 0;
        end else if (!m_ready) begin
            mdl[m_cnt] = 32'd0;
            m_cnt++;
            if (m_cnt == 32) m_ready = 1'b1;
        end else if (we && wa != 5'd0) mdl[wa] = wd;
    endtask
    task automatic wait_clear(input string tag);
        int n = 0;
        do begin
            cycle(1'b0, 1'b1, 5'd9, 32'h5A5A_0000, 1'b1, 5'd5, 1'b1, 5'd9);
            n++;
            #1;
        end while (rf.rf_ready !== 1'b1 && n < 40);
        check(tag, n, 32);
    endtask
    initial begin
        rf.wb_rd_enable = 1'b0; rf.wb_rd_addr = '0; rf.wb_rd_data = '0;
        rf.rs1_enable = 1'b0; rf.rs1_addr = '0; rf.rs2_enable = 1'b0; rf.rs2_addr = '0;
        @(posedge clk);
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b1, 5'd5);
        wait_clear("clr_len");
        cycle(1'b0, 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0, 5'd0);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b0, 5'd3);
        cycle(1'b0, 1'b1, 5'd7, 32'h1234_5678, 1'b1, 5'd7, 1'b1, 5'd7);
        cycle(1'b0, 1'b0, 5'd7, 32'd0, 1'b1, 5'd7, 1'b1, 5'd7);
        check("x7_lit", rf.rs1_data, 32'h1234_5678);
        check("x3_lit", mdl[3], 32'hDEAD_BEEF);
        cycle(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 1'b1, 5'd0);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b1, 5'd0);
        cycle(1'b0, 1'b0, 5'd4, 32'hAAAA_5555, 1'b1, 5'd4, 1'b1, 5'd4);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 1'b1, 5'd3);
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b1, 5'd3);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b1, 5'd5);
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b1, 5'd3);
        wait_clear("clr_len_restart");
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b1, 5'd7);
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 63) == 0, 1'($urandom), 5'($urandom), $urandom,
                  1'($urandom_range(0, 3) != 0), 5'($urandom), 1'($urandom_range(0, 3) != 0), 5'($urandom));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
